// File: rtl/vga_pix_pkg.sv
// rtl/vga_pix_pkg.sv - colour-depth types and pixel unpack helpers
// Purpose : shared types for the VGA pixel unpack FIFO.
//           cd_e   colour depth decoded from the 2-bit cd_i field
//           rgb_t  24-bit pixel
//           cd_from_bits / ppw / last_idx / unpack helper functions
package vga_pix_pkg;

   typedef enum logic [1:0] {
      CD_8GREY    = 2'd0,
      CD_16RGB565 = 2'd1,
      CD_32XRGB   = 2'd2
   } cd_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Both 10 and 11 select 32bpp.
   function automatic cd_e cd_from_bits(input logic [1:0] bits);
      case (bits)
         2'b00:   return CD_8GREY;
         2'b01:   return CD_16RGB565;
         default: return CD_32XRGB;
      endcase
   endfunction

   function automatic logic [2:0] ppw(input cd_e cd);
      case (cd)
         CD_8GREY:    return 3'd4;
         CD_16RGB565: return 3'd2;
         default:     return 3'd1;
      endcase
   endfunction

   // Index of the final pixel in a word (PPW-1), sized to match sub_idx.
   function automatic logic [1:0] last_idx(input cd_e cd);
      logic [2:0] n;
      n = ppw(cd) - 3'd1;
      return n[1:0];
   endfunction

   // Pixels are taken MSB first; shifting the selected pixel to the top
   // keeps the slice constant.
   function automatic rgb_t unpack(input logic [31:0] word, input cd_e cd,
                                   input logic [1:0] idx);
      rgb_t        p;
      logic [31:0] s;
      logic [15:0] h;
      p = '0;
      case (cd)
         CD_8GREY: begin
            s = word << {idx, 3'b000};
            p.r = s[31:24];
            p.g = s[31:24];
            p.b = s[31:24];
         end
         CD_16RGB565: begin
            s = word << {idx[0], 4'b0000};
            h = s[31:16];
            // Replicate top bits so full-scale 5/6-bit values map to 8'hFF.
            p.r = {h[15:11], h[15:13]};
            p.g = {h[10:5],  h[10:9]};
            p.b = {h[4:0],   h[4:2]};
         end
         default: begin
            p.r = word[23:16];
            p.g = word[15:8];
            p.b = word[7:0];
         end
      endcase
      return p;
   endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// rtl/vga_sync_fifo.sv - synchronous pointer FIFO with level and flush
// Purpose : single-clock word FIFO.
// Ports   : wb_clk, wb_rst (sync, active-high), i_flush (sync clear),
//           i_push/i_wdata write side, i_pop/o_rdata read side
//           (o_rdata shows the head word combinationally),
//           o_level word count, o_full, o_empty.
// The caller must not push when full or pop when empty.
module vga_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int WIDTH = 32
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [AW:0]      o_level,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;

   always_ff @(posedge wb_clk) begin
      if (wb_rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge wb_clk) begin
      if (i_push && !wb_rst && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;
   assign o_full  = (r_level == DEPTH[AW:0]);
   assign o_empty = (r_level == '0);

endmodule

// File: rtl/vga_pixel_unpack_fifo.sv
// rtl/vga_pixel_unpack_fifo.sv - word FIFO plus unpack to 24-bit RGB pixels
// Purpose : buffers 32-bit video words and presents one RGB pixel per
//           request, one cycle after the request.
// Ports   : wb_clk, wb_rst (sync, active-high)
//           clr_i / cd_i       frame flush, latches colour depth
//           wr_en_i / wr_dat_i word push; full_o, fill_req_o, level_o
//           pix_req_i          pixel request; pix_vld_o, pix_r/g/b_o
//           underrun_o, overflow_o sticky error flags
module vga_pixel_unpack_fifo
   import vga_pix_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int AE_LEVEL = 4
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        clr_i,
   input  logic [1:0]  cd_i,
   input  logic        wr_en_i,
   input  logic [31:0] wr_dat_i,
   output logic        full_o,
   output logic        fill_req_o,
   output logic [AW:0] level_o,
   input  logic        pix_req_i,
   output logic        pix_vld_o,
   output logic [7:0]  pix_r_o,
   output logic [7:0]  pix_g_o,
   output logic [7:0]  pix_b_o,
   output logic        underrun_o,
   output logic        overflow_o
);

   cd_e         r_cd_q;
   logic [31:0] r_hold_word;
   logic        r_hold_vld;
   logic [1:0]  r_sub_idx;
   logic        r_pix_vld;
   rgb_t        r_pix;
   logic        r_underrun;
   logic        r_overflow;

   logic [31:0] w_fifo_rdata;
   logic [AW:0] w_level;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_consume;
   logic        w_last;

   // A clear cycle discards both the write and the request.
   assign w_consume = pix_req_i && r_hold_vld && !clr_i;
   assign w_last    = (r_sub_idx == last_idx(r_cd_q));
   assign w_push    = wr_en_i && !w_full && !clr_i;
   // Refill the holding register when it is empty or its last pixel goes out.
   assign w_pop     = !w_empty && !clr_i && (!r_hold_vld || (w_consume && w_last));

   vga_sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .WIDTH (32)
   ) u_fifo (
      .wb_clk  (wb_clk),
      .wb_rst  (wb_rst),
      .i_flush (clr_i),
      .i_push  (w_push),
      .i_wdata (wr_dat_i),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_level (w_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_cd_q     <= cd_from_bits(cd_i);
         r_hold_vld <= 1'b0;
         r_sub_idx  <= '0;
         r_pix_vld  <= 1'b0;
         r_pix      <= '0;
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
      end else if (clr_i) begin
         // Pixel value is left alone so the display keeps its last colour.
         r_cd_q     <= cd_from_bits(cd_i);
         r_hold_vld <= 1'b0;
         r_sub_idx  <= '0;
         r_pix_vld  <= 1'b0;
         r_underrun <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_pix_vld <= w_consume;
         if (w_consume) r_pix <= unpack(r_hold_word, r_cd_q, r_sub_idx);
         if (pix_req_i && !r_hold_vld) r_underrun <= 1'b1;
         if (wr_en_i && w_full) r_overflow <= 1'b1;

         if (w_pop) begin
            r_hold_word <= w_fifo_rdata;
            r_hold_vld  <= 1'b1;
            r_sub_idx   <= '0;
         end else if (w_consume) begin
            if (w_last) begin
               r_hold_vld <= 1'b0;
               r_sub_idx  <= '0;
            end else begin
               r_sub_idx <= r_sub_idx + 1'b1;
            end
         end
      end
   end

   assign full_o     = w_full;
   assign level_o    = w_level;
   assign fill_req_o = (w_level <= AE_LEVEL[AW:0]);
   assign pix_vld_o  = r_pix_vld;
   assign pix_r_o    = r_pix.r;
   assign pix_g_o    = r_pix.g;
   assign pix_b_o    = r_pix.b;
   assign underrun_o = r_underrun;
   assign overflow_o = r_overflow;

endmodule
